// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, instruction-memory request issue,
// 2-entry response FIFO towards the decoder, redirect handling with stale
// response discard, and misaligned-PC address-error injection.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        id_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic        fetch_adel
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adel;
    } fentry_t;

    // fetch PC and address-error latch
    logic [31:0] r_pc;
    logic        r_adel_pending;

    // in-flight bookkeeping: outstanding count, responses to drop, request PCs
    logic [1:0]  r_out_cnt;
    logic [1:0]  r_discard;
    logic [31:0] r_pcq [2];
    logic        r_pq_wr;
    logic        r_pq_rd;

    // decoder-facing FIFO
    fentry_t     r_fifo [2];
    logic        r_f_wr;
    logic        r_f_rd;
    logic [1:0]  r_f_cnt;

    logic        w_pop;
    logic [2:0]  w_occ;
    logic        w_room;
    logic        w_aligned;
    logic        w_issue;
    logic        w_rsp_push;
    logic        w_adel_push;
    logic        w_push;
    fentry_t     w_push_entry;
    fentry_t     w_head;

    // Slots already claimed: every outstanding request must land in the FIFO,
    // so in-flight requests count against FIFO capacity. A pop this cycle
    // frees a slot early, which is what allows 1 instruction/cycle.
    assign w_pop     = inst_valid & id_ready;
    assign w_occ     = {1'b0, r_out_cnt} + {1'b0, r_f_cnt} - {2'b00, w_pop};
    assign w_room    = (w_occ < 3'd2);
    assign w_aligned = (r_pc[1:0] == 2'b00);

    assign imem_req  = resetn & w_room & ~redirect_valid & w_aligned & ~r_adel_pending;
    assign imem_addr = r_pc;
    assign w_issue   = imem_req & imem_gnt;

    // A misaligned PC is reported only after the pipe has drained so the
    // error entry stays in program order behind older instructions.
    assign w_rsp_push  = imem_rvalid & (r_discard == 2'd0);
    assign w_adel_push = ~w_aligned & ~r_adel_pending & (r_out_cnt == 2'd0) &
                         (r_f_cnt == 2'd0) & ~redirect_valid;
    assign w_push      = (w_rsp_push | w_adel_push) & ~redirect_valid;

    always_comb begin
        w_push_entry = '0;
        if (w_adel_push) begin
            w_push_entry.pc   = r_pc;
            w_push_entry.adel = 1'b1;
        end else begin
            w_push_entry.inst = imem_rdata;
            w_push_entry.pc   = r_pcq[r_pq_rd];
        end
    end

    assign inst_valid  = (r_f_cnt != 2'd0);
    assign w_head      = r_fifo[r_f_rd];
    assign instruction = inst_valid ? w_head.inst : 32'd0;
    assign inst_pc     = inst_valid ? w_head.pc   : 32'd0;
    assign fetch_adel  = inst_valid & w_head.adel;

    // PC advance on issue; redirect overrides and clears the address-error stop
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc           <= RESET_PC;
            r_adel_pending <= 1'b0;
        end else if (redirect_valid) begin
            r_pc           <= redirect_pc;
            r_adel_pending <= 1'b0;
        end else begin
            if (w_issue)
                r_pc <= r_pc + PC_STEP;
            if (w_adel_push)
                r_adel_pending <= 1'b1;
        end
    end

    // Outstanding count, discard count and in-order request-PC queue.
    // Discarded responses still retire their PC queue entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_cnt <= 2'd0;
            r_discard <= 2'd0;
            r_pcq[0]  <= 32'd0;
            r_pcq[1]  <= 32'd0;
            r_pq_wr   <= 1'b0;
            r_pq_rd   <= 1'b0;
        end else begin
            r_out_cnt <= r_out_cnt + {1'b0, w_issue} - {1'b0, imem_rvalid};
            if (redirect_valid)
                r_discard <= r_out_cnt - {1'b0, imem_rvalid};
            else if (imem_rvalid && (r_discard != 2'd0))
                r_discard <= r_discard - 2'd1;
            if (w_issue) begin
                r_pcq[r_pq_wr] <= r_pc;
                r_pq_wr        <= ~r_pq_wr;
            end
            if (imem_rvalid)
                r_pq_rd <= ~r_pq_rd;
        end
    end

    // Decoder FIFO; a redirect flushes it, swallowing any same-cycle push/pop
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_f_wr    <= 1'b0;
            r_f_rd    <= 1'b0;
            r_f_cnt   <= 2'd0;
        end else if (redirect_valid) begin
            r_f_wr    <= 1'b0;
            r_f_rd    <= 1'b0;
            r_f_cnt   <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_f_wr] <= w_push_entry;
                r_f_wr         <= ~r_f_wr;
            end
            if (w_pop)
                r_f_rd <= ~r_f_rd;
            r_f_cnt <= r_f_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // The issue limit must make a push into a full FIFO unreachable
    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(w_push && (r_f_cnt == 2'd2)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural instruction memory returning
// word = address with programmable latency, plus a scoreboard of expected
// decoder-side entries consumed in order.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        id_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        fetch_adel;

    int checks   = 0;
    int errors   = 0;
    int consumed = 0;
    int mem_lat  = 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    typedef struct {
        logic [31:0] a;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int    cyc;

    fetch_unit dut (
        .clk            (clk),
        .resetn         (resetn),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (mem_rvalid),
        .imem_rdata     (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .id_ready       (id_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc),
        .fetch_adel     (fetch_adel)
    );

    always #5 clk = ~clk;

    // in-order memory: response visible mem_lat cycles after issue, one per cycle
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mq.delete();
            mem_rvalid <= 1'b0;
            mem_rdata  <= 32'd0;
            cyc        <= 0;
        end else begin
            if (imem_req && imem_gnt)
                mq.push_back(mreq_t'{imem_addr, cyc + mem_lat - 1});
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= mq[0].a;
                void'(mq.pop_front());
            end else begin
                mem_rvalid <= 1'b0;
            end
            cyc <= cyc + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(exp_t'{start + 32'(i * 4), start + 32'(i * 4), 1'b0});
    endtask

    // redirect for one edge; expected stream restarts at the target
    task automatic do_redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        exp_q.delete();
        if (tgt[1:0] == 2'b00)
            push_seq(tgt, 40);
        else
            exp_q.push_back(exp_t'{tgt, 32'd0, 1'b1});
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_consumed(input string tag, input int n);
        int target;
        target = consumed + n;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (consumed >= target) break;
        end
        #2;
        chk(tag, 32'(consumed >= target), 32'd1);
    endtask

    initial begin
        logic [31:0] hold;
        logic [31:0] t1_pc [5];
        logic        t1_v  [5];

        resetn         = 1'b0;
        imem_gnt       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        id_ready       = 1'b1;

        // scoreboard: every consumed head (not killed by redirect) is compared
        fork
            forever begin
                @(negedge clk);
                if (resetn && inst_valid && id_ready && !redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_pc",   inst_pc,            e.pc);
                        chk("sb_inst", instruction,        e.inst);
                        chk("sb_adel", {31'd0, fetch_adel}, {31'd0, e.adel});
                        consumed++;
                    end
                end
            end
        join_none

        // reset state, no clock edge yet
        #1;
        chk("rst_req",   {31'd0, imem_req},   32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst",  instruction,         32'd0);
        chk("rst_pc",    inst_pc,             32'd0);
        chk("rst_adel",  {31'd0, fetch_adel}, 32'd0);

        // T1: first-fetch latency and 1/cycle throughput
        push_seq(RST_PC, 40);
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
        t1_v  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        t1_pc = '{32'd0, 32'd0, RST_PC, RST_PC + 32'd4, RST_PC + 32'd8};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("t1_req", {31'd0, imem_req}, 32'd1);
                chk("t1_addr", imem_addr, RST_PC);
            end
            chk("t1_valid", {31'd0, inst_valid}, {31'd0, t1_v[i]});
            chk("t1_pc", inst_pc, t1_pc[i]);
        end
        step();

        // T2: decoder stall holds the head and throttles requests
        step();
        id_ready = 1'b0;
        hold     = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) hold = inst_pc;
            else chk("t2_hold", inst_pc, hold);
            chk("t2_valid", {31'd0, inst_valid}, 32'd1);
            chk("t2_req",   {31'd0, imem_req},   32'd0);
        end
        step();
        id_ready = 1'b1;
        wait_consumed("t2_resume", 6);

        // T3: redirect with two requests in flight
        mem_lat = 3;
        for (int i = 0; i < 30; i++) begin
            step();
            if (!imem_req && !inst_valid) break;
        end
        chk("t3_two_out", {30'd0, imem_req, inst_valid}, 32'd0);
        do_redirect(32'h8000_0100);
        wait_consumed("t3_stream", 4);
        mem_lat = 1;
        wait_consumed("t3_lat1", 2);

        // T4: misaligned target produces one address-error entry then stops
        do_redirect(32'h8000_0102);
        wait_consumed("t4_adel", 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_req_off", {31'd0, imem_req},   32'd0);
            chk("t4_single",  {31'd0, inst_valid}, 32'd0);
        end
        step();
        do_redirect(32'h8000_0180);
        wait_consumed("t4_resume", 4);

        // T5: response, pop and redirect in the same cycle
        step();
        chk("t5_pre", {30'd0, mem_rvalid, inst_valid}, 32'd3);
        do_redirect(32'h0040_0000);
        chk("t5_empty", {31'd0, inst_valid}, 32'd0);
        wait_consumed("t5_stream", 4);

        // T6: grant withheld holds the address
        step();
        imem_gnt = 1'b0;
        hold     = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) hold = imem_addr;
            else chk("t6_addr_hold", imem_addr, hold);
        end
        step();
        imem_gnt = 1'b1;
        wait_consumed("t6_resume", 4);

        // T7: reset mid-stream clears outputs at once and restarts at RESET_PC
        resetn = 1'b0;
        #1;
        chk("t7_req",   {31'd0, imem_req},   32'd0);
        chk("t7_valid", {31'd0, inst_valid}, 32'd0);
        chk("t7_inst",  instruction,         32'd0);
        chk("t7_pc",    inst_pc,             32'd0);
        chk("t7_adel",  {31'd0, fetch_adel}, 32'd0);
        exp_q.delete();
        push_seq(RST_PC, 40);
        step();
        step();
        resetn = 1'b1;
        wait_consumed("t7_restart", 5);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
